// File: rtl/axi_burst_writer.sv
// AXI4 write master: splits a beat-count write command into INCR bursts that are
// capped at MAX_BURST beats and never cross a 4 KB boundary.
module axi_burst_writer #(
    parameter int                  DATA_WIDTH  = 64,
    parameter int                  ADDR_WIDTH  = 29,
    parameter int                  ID_WIDTH    = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID      = '1,
    parameter int                  MAX_BURST   = 256,
    parameter int                  BEATS_WIDTH = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [BEATS_WIDTH-1:0]    cmd_beats,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      done,
    output logic                      err,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SIZE   = $clog2(STRB_W);
    localparam int LEN_W  = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        BURST = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [BEATS_WIDTH-1:0] remaining;
    logic [LEN_W-1:0]       len, beat_cnt, len_calc;
    logic [12:0]            to_4k;
    logic                   aw_done, w_done, err_acc;
    logic                   aw_hs, w_hs, b_hs;
    logic                   sig_unused;

    function automatic logic [LEN_W-1:0] burst_len(input logic [BEATS_WIDTH-1:0] rem,
                                                   input logic [12:0] room);
        logic [31:0] n;
        n = 32'(rem);
        if (n > 32'(MAX_BURST)) n = 32'(MAX_BURST);
        if (n > 32'(room)) n = 32'(room);
        return n[LEN_W-1:0];
    endfunction

    // Beats left before the next 4 KB page, then the clipped burst length
    assign to_4k    = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE;
    assign len_calc = burst_len(remaining, to_4k);

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_wstrb   = '1;
    assign m_axi_wdata   = s_data;

    assign m_axi_awvalid = (state == BURST) & ~aw_done;
    assign m_axi_wvalid  = (state == BURST) & ~w_done & s_valid;
    assign m_axi_wlast   = m_axi_wvalid & (beat_cnt == len - 9'd1);
    assign m_axi_bready  = (state == RESP);
    assign s_ready       = m_axi_wvalid & m_axi_wready;
    assign cmd_ready     = (state == IDLE);
    assign done          = (state == DONE);
    assign err           = (state == DONE) & err_acc;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bvalid & m_axi_bready;

    assign sig_unused = ^{m_axi_bid, cmd_addr[SIZE-1:0]};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = (cmd_beats == '0) ? DONE : CALC;
            CALC:    state_nxt = BURST;
            BURST:   if ((aw_done | aw_hs) & (w_done | (w_hs & m_axi_wlast))) state_nxt = RESP;
            RESP:    if (b_hs) state_nxt = (remaining != BEATS_WIDTH'(len)) ? CALC : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr         <= '0;
            remaining    <= '0;
            len          <= '0;
            beat_cnt     <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            err_acc      <= 1'b0;
            m_axi_awaddr <= '0;
            m_axi_awlen  <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    addr      <= {cmd_addr[ADDR_WIDTH-1:SIZE], {SIZE{1'b0}}};
                    remaining <= cmd_beats;
                    err_acc   <= 1'b0;
                end
                CALC: begin
                    len          <= len_calc;
                    m_axi_awaddr <= addr;
                    m_axi_awlen  <= 8'(len_calc - 9'd1);
                    aw_done      <= 1'b0;
                    w_done       <= 1'b0;
                    beat_cnt     <= '0;
                end
                BURST: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (m_axi_wlast) w_done <= 1'b1;
                    end
                end
                RESP: if (b_hs) begin
                    err_acc   <= err_acc | (m_axi_bresp != 2'b00);
                    addr      <= addr + (ADDR_WIDTH'(len) << SIZE);
                    remaining <= remaining - BEATS_WIDTH'(len);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_writer.sv
// Scoreboard bench for axi_burst_writer: directed commands push expected AW/W/done
// entries; a negedge monitor pops and compares whenever the DUT presents a handshake.
`timescale 1ns/1ps
module tb_axi_burst_writer;
    localparam int DW  = 64;
    localparam int AW  = 29;
    localparam int IDW = 4;
    localparam int BW  = 16;

    logic           ACLK, ARESETN;
    logic           cmd_valid, cmd_ready;
    logic [AW-1:0]  cmd_addr;
    logic [BW-1:0]  cmd_beats;
    logic [DW-1:0]  s_data;
    logic           s_valid, s_ready, done, err;
    logic [IDW-1:0] m_axi_awid;
    logic [AW-1:0]  m_axi_awaddr;
    logic [7:0]     m_axi_awlen;
    logic [2:0]     m_axi_awsize;
    logic [1:0]     m_axi_awburst;
    logic           m_axi_awlock;
    logic [3:0]     m_axi_awcache;
    logic [2:0]     m_axi_awprot;
    logic [3:0]     m_axi_awqos;
    logic           m_axi_awvalid, m_axi_awready;
    logic [DW-1:0]  m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic           m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [IDW-1:0] m_axi_bid;
    logic [1:0]     m_axi_bresp;
    logic           m_axi_bvalid, m_axi_bready;

    axi_burst_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .AXI_ID(4'hF),
        .MAX_BURST(256), .BEATS_WIDTH(BW)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .done(done), .err(err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    // Scoreboard queues: pushed by the stimulus, popped by the monitor
    logic [AW-1:0] exp_aw_addr[$];
    int            exp_aw_len[$];
    logic [DW-1:0] exp_wd[$];
    bit            exp_wl[$];
    bit            exp_err[$];
    int            exp_nbeats[$];
    logic [DW-1:0] fifo_q[$];
    logic [1:0]    bresp_q[$];

    int checks, errors;
    int cyc, aw_cnt, wl_cnt, b_cnt, b_owed, cmd_w, burst_w, b_cyc, aw_wait, tmo_seen;
    bit aw_in_burst, w_hs_f, b_hs_f, prev_rst, end_done;
    int aw_delay, rand_mode, tmo_pending, end_req, tid, seq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Monitor: samples on the falling edge, away from the active edge
    initial begin
        checks = 0; errors = 0; cyc = 0; aw_cnt = 0; wl_cnt = 0; b_cnt = 0; b_owed = 0;
        cmd_w = 0; burst_w = 0; b_cyc = 0; aw_wait = 0; tmo_seen = 0;
        aw_in_burst = 0; w_hs_f = 0; b_hs_f = 0; prev_rst = 0; end_done = 0;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (tmo_pending != tmo_seen) begin
                tmo_seen++; checks++; errors++;
                $display("FAIL timeout actual=expired required=done");
            end
            if (!ARESETN) begin
                chk("rst_cmd_ready", cmd_ready, 1);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                chk("rst_awvalid", m_axi_awvalid, 0);
                chk("rst_wvalid", m_axi_wvalid, 0);
                chk("rst_wlast", m_axi_wlast, 0);
                chk("rst_bready", m_axi_bready, 0);
                chk("rst_s_ready", s_ready, 0);
                chk("rst_awaddr", m_axi_awaddr, 0);
                chk("rst_awlen", m_axi_awlen, 0);
                aw_cnt = 0; wl_cnt = 0; b_cnt = 0; b_owed = 0; cmd_w = 0; burst_w = 0;
                aw_wait = 0; aw_in_burst = 0; w_hs_f = 0; b_hs_f = 0; prev_rst = 1;
            end else begin
                if (prev_rst) chk("post_rst_cmd_ready", cmd_ready, 1);
                prev_rst = 0;
                if (m_axi_wvalid) begin
                    chk("wvalid_needs_svalid", s_valid, 1);
                    chk("s_ready_is_w_hs", s_ready, m_axi_wready);
                end
                if (m_axi_bready) chk("resp_after_aw", aw_in_burst, 1);
                if (m_axi_awvalid && m_axi_awready) begin
                    if (exp_aw_addr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_aw actual=%0h required=none", m_axi_awaddr);
                    end else begin
                        chk("awaddr", m_axi_awaddr, exp_aw_addr.pop_front());
                        chk("awlen", m_axi_awlen, exp_aw_len.pop_front());
                        chk("awsize", m_axi_awsize, 3);
                        chk("awburst", m_axi_awburst, 1);
                        chk("awcache", m_axi_awcache, 4'b0011);
                        chk("aw_misc", {m_axi_awid, m_axi_awlock, m_axi_awprot, m_axi_awqos, m_axi_wstrb},
                            {4'hF, 1'b0, 3'b000, 4'h0, 8'hFF});
                        chk("no_4k_cross", (32'(m_axi_awaddr[11:0]) + (32'(m_axi_awlen) + 1) * 8) <= 4096, 1);
                        if (aw_delay > 0) chk("w_before_aw", burst_w, 32'(m_axi_awlen) + 1);
                    end
                    aw_cnt++; aw_in_burst = 1; aw_wait = 0;
                end else if (m_axi_awvalid) aw_wait++;
                if (m_axi_wvalid && m_axi_wready) begin
                    if (exp_wd.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_w actual=%0h required=none", m_axi_wdata);
                    end else begin
                        chk("wdata", m_axi_wdata, exp_wd.pop_front());
                        chk("wlast", m_axi_wlast, exp_wl.pop_front());
                    end
                    cmd_w++; burst_w++;
                    if (m_axi_wlast) wl_cnt++;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    b_cnt++; b_cyc = cyc; burst_w = 0; aw_in_burst = 0;
                end
                if (done) begin
                    if (exp_err.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done actual=1 required=0");
                    end else begin
                        int nb;
                        nb = exp_nbeats.pop_front();
                        chk("done_err", err, exp_err.pop_front());
                        chk("beats_per_cmd", cmd_w, nb);
                        if (nb != 0) chk("done_latency", cyc - b_cyc, 1);
                    end
                    cmd_w = 0;
                end
                if (end_req != 0 && !end_done) begin
                    end_done = 1;
                    chk("aw_left", exp_aw_addr.size(), 0);
                    chk("w_left", exp_wd.size(), 0);
                    chk("fifo_left", fifo_q.size(), 0);
                end
                w_hs_f = m_axi_wvalid & m_axi_wready;
                b_hs_f = m_axi_bvalid & m_axi_bready;
                b_owed = ((aw_cnt < wl_cnt) ? aw_cnt : wl_cnt) - b_cnt;
            end
        end
    end

    // Slave and FIFO driver: updates inputs just after the active edge
    initial begin
        s_valid = 0; s_data = '0; m_axi_awready = 0; m_axi_wready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 2'b00; m_axi_bid = 4'hF;
        forever begin
            bit s_gate;
            @(posedge ACLK);
            #1;
            if (w_hs_f && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (b_hs_f && bresp_q.size() > 0) void'(bresp_q.pop_front());
            s_gate        = (rand_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_axi_wready  = (rand_mode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_axi_awready = (aw_wait >= aw_delay);
            s_valid       = s_gate && (fifo_q.size() > 0);
            s_data        = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            m_axi_bvalid  = (b_owed > 0);
            m_axi_bresp   = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
        end
    end

    task automatic exp_burst(input logic [AW-1:0] a, input int len, input logic [1:0] resp);
        exp_aw_addr.push_back(a);
        exp_aw_len.push_back(len - 1);
        bresp_q.push_back(resp);
        for (int i = 0; i < len; i++) begin
            logic [DW-1:0] d;
            seq++;
            d = {16'hC0DE, 16'(tid), 32'(seq)};
            exp_wd.push_back(d);
            exp_wl.push_back(i == len - 1);
            fifo_q.push_back(d);
        end
    endtask

    task automatic issue(input logic [AW-1:0] a, input int beats, input bit e);
        exp_err.push_back(e);
        exp_nbeats.push_back(beats);
        cmd_addr  = a;
        cmd_beats = BW'(beats);
        cmd_valid = 1;
        @(posedge ACLK);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_err.size() != 0 && n < budget) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        if (exp_err.size() != 0) begin
            tmo_pending++;
            exp_err.delete(); exp_nbeats.delete();
            @(posedge ACLK);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN = 0; cmd_valid = 0; cmd_addr = '0; cmd_beats = '0;
        aw_delay = 0; rand_mode = 0; tmo_pending = 0; end_req = 0; tid = 0; seq = 0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1;
        @(posedge ACLK);
        #1;

        tid = 1;
        exp_burst(29'h000, 16, 2'b00);
        issue(29'h000, 16, 0);
        wait_done(200);

        tid = 2;
        exp_burst(29'h0FC0, 8, 2'b00);
        exp_burst(29'h1000, 8, 2'b00);
        issue(29'h0FC0, 16, 0);
        wait_done(200);

        // 300 beats from 0: a full 256-beat burst ends at 0x800, the last 44 fit one burst
        tid = 3;
        exp_burst(29'h000, 256, 2'b00);
        exp_burst(29'h800, 44, 2'b00);
        issue(29'h000, 300, 0);
        wait_done(1000);

        tid = 4;
        aw_delay = 5;
        exp_burst(29'h100, 4, 2'b00);
        issue(29'h100, 4, 0);
        wait_done(200);
        aw_delay = 0;

        tid = 5;
        rand_mode = 1;
        exp_burst(29'h2000, 40, 2'b00);
        issue(29'h2000, 40, 0);
        wait_done(1000);
        rand_mode = 0;

        tid = 6;
        issue(29'h300, 0, 0);
        wait_done(20);

        tid = 7;
        exp_burst(29'h3000, 2, 2'b00);
        issue(29'h3005, 2, 0);
        wait_done(100);

        tid = 8;
        exp_burst(29'h0F80, 16, 2'b00);
        exp_burst(29'h1000, 16, 2'b10);
        issue(29'h0F80, 32, 1);
        wait_done(300);

        // Reset in the middle of a 64-beat burst; the command is dropped
        tid = 9;
        exp_burst(29'h000, 64, 2'b00);
        issue(29'h000, 64, 0);
        repeat (20) @(posedge ACLK);
        #1;
        ARESETN = 0;
        repeat (3) @(posedge ACLK);
        #1;
        exp_aw_addr.delete(); exp_aw_len.delete(); exp_wd.delete(); exp_wl.delete();
        exp_err.delete(); exp_nbeats.delete(); fifo_q.delete(); bresp_q.delete();
        ARESETN = 1;
        repeat (20) @(posedge ACLK);
        #1;

        tid = 10;
        exp_burst(29'h040, 8, 2'b00);
        issue(29'h040, 8, 0);
        wait_done(200);

        end_req = 1;
        repeat (3) @(posedge ACLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
